// File: rtl/mem_wb_hilo.sv
// MEM/WB pipeline register and architectural HI/LO register file.
// Latency: mem_* at cycle N drive wb_* at N+1; HI/LO commit at the end of N+1, bypassed to hi_o/lo_o during N+1.
// Backpressure: stall_wb holds the stage and defers any commit; stall_mem without stall_wb inserts a bubble.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mem_wreg/wd/wdata                GPR write bundle from MEM
//   mem_whilo/hi/lo                  HI/LO write bundle from MEM
//   stall_mem, stall_wb, flush       pipeline control
//   wb_wreg/wd/wdata                 GPR write port to the regfile
//   wb_whilo                         HI/LO write pending in WB
//   hi_o, lo_o                       HI/LO with the WB stage bypassed, for MFHI/MFLO in EX
//   gpr_wr_cnt, hilo_wr_cnt          retire counters, present only with `define WB_PERF_CNT_EN
module mem_wb_hilo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  output logic              wb_wreg,
  output logic [ADDR_W-1:0] wb_wd,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_whilo,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
`ifdef WB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  gpr_wr_cnt,
  output logic [CNT_W-1:0]  hilo_wr_cnt
`endif
);

  typedef struct packed {
    logic              wreg;
    logic [ADDR_W-1:0] wd;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } stage_t;

  stage_t            stage;
  stage_t            mem_bundle;
  logic [DATA_W-1:0] arch_hi;
  logic [DATA_W-1:0] arch_lo;

  // Whatever sits in WB retires at this edge unless WB itself is stalled.
  logic retire;
  assign retire = !stall_wb;

  always_comb begin
    mem_bundle       = '0;
    mem_bundle.wreg  = mem_wreg;
    mem_bundle.wd    = mem_wd;
    mem_bundle.wdata = mem_wdata;
    mem_bundle.whilo = mem_whilo;
    mem_bundle.hi    = mem_hi;
    mem_bundle.lo    = mem_lo;
  end

  // Stage register. A stalled MEM with a free WB must not let its
  // instruction advance, so WB receives a bubble instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else if (flush || (stall_mem && !stall_wb)) begin
      stage <= '0;
    end else if (!stall_wb) begin
      stage <= mem_bundle;
    end
  end

  // Architectural HI/LO. The commit uses the stage contents present at this
  // edge, so a flush still lets an instruction already in WB complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      arch_hi <= '0;
      arch_lo <= '0;
    end else if (stage.whilo && retire) begin
      arch_hi <= stage.hi;
      arch_lo <= stage.lo;
    end
  end

  assign wb_wreg  = stage.wreg;
  assign wb_wd    = stage.wd;
  assign wb_wdata = stage.wdata;
  assign wb_whilo = stage.whilo;

  // Only the WB stage is forwarded here; younger producers are handled in EX.
  assign hi_o = stage.whilo ? stage.hi : arch_hi;
  assign lo_o = stage.whilo ? stage.lo : arch_lo;

`ifdef WB_PERF_CNT_EN
  // Counters wrap naturally; flush does not touch them.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_wr_cnt  <= '0;
      hilo_wr_cnt <= '0;
    end else begin
      if (stage.wreg && retire) gpr_wr_cnt <= gpr_wr_cnt + 1'b1;
      if (stage.whilo && retire) hilo_wr_cnt <= hilo_wr_cnt + 1'b1;
    end
  end
`endif

endmodule
